alu_pipe_param: RTL and testbench
=================================

Name: alu_pipe_param

Overview:
- Parametrised next-generation ALU with NZCV flags.
- Adds a registered output stage with a valid/ready handshake on both sides.
- Adds a persistent flag register, an add-with-carry mode that reads it, XOR and signed-compare modes, and an iterative multi-cycle multiply.
- Sits between the register-file read stage and writeback of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select (see Behaviour).
- set_flags  input  1  when high, the accepted op updates the flag register.
- out_valid  output  1  result held in the output register.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- flags  output  4  flag register {N,Z,C,V}.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset mid-operation, including mid-multiply, aborts all work.
- Reset values: state=IDLE, out_valid=0, result=0, flags=4'b0000, in_ready=0 during the reset cycle.
- Op encoding:
  - 000 ADD a+b.
  - 001 SUB a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: result = {0..,1} if signed a<b, else 0.
  - 110 ADC a+b+flags.C.
  - 111 MUL: low WIDTH bits of unsigned a*b.
- Accept: a transfer happens on a cycle with in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops (000-110): result and flags are written on the clock edge of acceptance. Latency 1; out_valid=1 the next cycle.
- MUL: inputs and set_flags are latched at accept and state goes to MUL. Shift-add runs one bit per cycle for WIDTH cycles. On the final iteration the output register and flags are written, out_valid=1, and state returns to IDLE. Latency WIDTH cycles; in_ready=0 throughout.
- Output hold: while out_valid && !out_ready, result and flags stay stable and no new op is accepted.
- Back-to-back: with out_ready=1 and in_valid=1 continuously, single-cycle ops sustain one result per cycle.
- Flag rules (written only if set_flags was high at accept; otherwise flags hold):
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB: C = carry out of a+~b+1 (1 = no borrow, a>=b unsigned); V = signed overflow.
  - AND/OR/XOR/SLT/MUL: C=0, V=0.
- ADC read timing: ADC reads the flag register value present in the cycle of acceptance. Because flags commit at the accepting edge, an ADC issued the cycle after a flag-setting ADD sees that ADD's carry.
- Width rules: all arithmetic is modulo 2^WIDTH. SLT uses a WIDTH+1 bit signed subtraction, so it never overflows.
- Counter: WIDTH-1 down to 0. No wrap hazard.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADC, OP_MUL);
  - typedef enum state_t {IDLE, MUL};
  - localparam flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module: alu_mul_iter #(WIDTH). Interface: start, a, b, busy, done, product. Owns the multiply counter and accumulator. The top level owns the handshake, the combinational single-cycle datapath and the flag register.

Test Plan:
- Reset then ADD: a=32'h7FFF_FFFF, b=1, set_flags=1 -> next cycle out_valid=1, result=32'h8000_0000, flags=4'b1001 (N,V).
- SUB equal: a=b=32'h1234_5678, set_flags=1 -> result=0, flags=4'b0110 (Z,C).
- ADC chain: ADD a=32'hFFFF_FFFF, b=1, set_flags=1, then next cycle ADC a=0, b=0 -> first result 0 with C=1; second result 1.
- MUL with backpressure: a=1000, b=3000, out_ready=0 -> in_ready=0 for 32 cycles, then result=3_000_000 and out_valid held until out_ready=1; a second in_valid is not accepted meanwhile.
- SLT signed and set_flags=0: a=32'hFFFF_FFFF (-1), b=1 -> result=1, flags unchanged from prior value.
- Reset mid-MUL: assert reset 10 cycles into MUL -> next cycle out_valid=0, flags=0, state IDLE, in_ready=1 after reset deasserts. Repeat at WIDTH=8 with MUL 15*17 -> result=8'hFF, latency 8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: op encoding, control
// states and the bit positions of the NZCV flag register.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_ADC = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for WIDTH
// cycles, producing the low WIDTH bits of the unsigned product.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // The final partial sum is exposed combinationally so the top level can
    // register it on the same edge as the last iteration.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        product  = acc_next;
        done     = busy && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Parametrised ALU with a registered valid/ready output stage, a persistent
// NZCV flag register and an iterative multiply path.
module alu_pipe_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_t           state;
    state_t           state_next;
    alu_op_t          op_sel;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_set_flags;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;
    logic             slt_lt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return pack_flags(r[WIDTH-1], r == '0, c, v);
    endfunction

    assign op_sel    = alu_op_t'(op);
    assign in_ready  = !reset && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_sel == OP_MUL);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (mul_start) state_next = MUL;
            MUL:  if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ADD, SUB and ADC share one adder; ADC takes its carry-in from the flag
    // register as it stands in the accepting cycle.
    always_comb begin
        add_b   = (op_sel == OP_SUB) ? ~b : b;
        add_cin = 1'b0;
        if (op_sel == OP_SUB) begin
            add_cin = 1'b1;
        end else if (op_sel == OP_ADC) begin
            add_cin = flags[FLAG_C];
        end
        add_sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        add_ovf = (a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
        slt_lt  = $signed({a[WIDTH-1], a}) < $signed({b[WIDTH-1], b});
    end

    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        unique case (op_sel)
            OP_ADD, OP_SUB, OP_ADC: begin
                alu_result = add_sum[WIDTH-1:0];
                alu_c      = add_sum[WIDTH];
                alu_v      = add_ovf;
            end
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_XOR: alu_result = a ^ b;
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_MUL: alu_result = '0;
            default: alu_result = '0;
        endcase
    end

    // Output register: a finishing multiply wins, then a single-cycle accept,
    // otherwise the consumer may drain the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            result        <= '0;
            flags         <= 4'b0000;
            mul_set_flags <= 1'b0;
        end else begin
            if (mul_start) begin
                mul_set_flags <= set_flags;
            end
            if ((state == MUL) && mul_done) begin
                result    <= mul_product;
                out_valid <= 1'b1;
                if (mul_set_flags) begin
                    flags <= make_flags(mul_product, 1'b0, 1'b0);
                end
            end else if (accept && (op_sel != OP_MUL)) begin
                result    <= alu_result;
                out_valid <= 1'b1;
                if (set_flags) begin
                    flags <= make_flags(alu_result, alu_c, alu_v);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param at WIDTH=32 and WIDTH=8, checked against an
// arithmetic reference model of the ALU rules.
module tb_alu_pipe_param;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, set_flags, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  op;
    logic [3:0]  flags;

    logic        reset8, in_valid8, in_ready8, set_flags8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [2:0]  op8;
    logic [3:0]  flags8;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  mflags, mflags8;

    always #5 clk = ~clk;

    alu_pipe_param #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .set_flags(set_flags), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    alu_pipe_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .set_flags(set_flags8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .flags(flags8)
    );

    // Reference: plain integer arithmetic on w-bit values, flags as {N,Z,C,V}.
    function automatic void model(input int w, input int opc,
                                  input longint unsigned ua, input longint unsigned ub,
                                  input bit cin, output longint unsigned res,
                                  output logic [3:0] fl);
        longint unsigned mask, u;
        longint sa, sb, t, smax, smin;
        bit c, v;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(ua);
        sb = longint'(ub);
        if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        c = 1'b0;
        v = 1'b0;
        res = 0;
        case (opc)
            0: begin u = ua + ub; res = u & mask; c = (u >> w) != 0;
                     t = sa + sb; v = (t > smax) || (t < smin); end
            1: begin res = (ua - ub) & mask; c = ua >= ub;
                     t = sa - sb; v = (t > smax) || (t < smin); end
            2: res = ua & ub;
            3: res = ua | ub;
            4: res = ua ^ ub;
            5: res = (sa < sb) ? 64'd1 : 64'd0;
            6: begin u = ua + ub + longint'(cin); res = u & mask; c = (u >> w) != 0;
                     t = sa + sb + longint'(cin); v = (t > smax) || (t < smin); end
            default: res = (ua * ub) & mask;
        endcase
        fl = {((res >> (w - 1)) & 64'd1) != 0, res == 0, c, v};
    endfunction

    function automatic longint unsigned pick(input int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 0;
            1: return m;
            2: return 64'd1 << (w - 1);
            3: return (64'd1 << (w - 1)) - 64'd1;
            default: return longint'($urandom) & m;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
        checks++;
        if (flags !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", flags); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        mflags = 4'b0000;
    endtask

    task automatic test_add_overflow();
        in_valid = 1'b1; op = 3'd0; a = 32'h7FFF_FFFF; b = 32'h1; set_flags = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000)
            begin failures++; $display("[TB] FAIL add_ovf_result got=%b/%h exp=1/80000000", out_valid, result); end
        checks++;
        if (flags !== 4'b1001) begin failures++; $display("[TB] FAIL add_ovf_flags got=%b exp=1001", flags); end
        mflags = 4'b1001;
    endtask

    task automatic test_sub_equal();
        in_valid = 1'b1; op = 3'd1; a = 32'h1234_5678; b = 32'h1234_5678; set_flags = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'h0) begin failures++; $display("[TB] FAIL sub_eq_result got=%h exp=0", result); end
        checks++;
        if (flags !== 4'b0110) begin failures++; $display("[TB] FAIL sub_eq_flags got=%b exp=0110", flags); end
        mflags = 4'b0110;
    endtask

    task automatic test_adc_chain();
        in_valid = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'h1; set_flags = 1'b1;
        tick();
        checks++;
        if (result !== 32'h0 || flags !== 4'b0110)
            begin failures++; $display("[TB] FAIL adc_chain_add got=%h/%b exp=0/0110", result, flags); end
        op = 3'd6; a = 32'h0; b = 32'h0; set_flags = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h1)
            begin failures++; $display("[TB] FAIL adc_chain_adc got=%b/%h exp=1/1", out_valid, result); end
        checks++;
        if (flags !== 4'b0110) begin failures++; $display("[TB] FAIL adc_chain_hold got=%b exp=0110", flags); end
        mflags = 4'b0110;
    endtask

    task automatic test_back_to_back();
        longint unsigned ra, rb, er;
        logic [3:0] ef;
        int opc;
        bit sf;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            opc = $urandom_range(0, 6);
            ra = pick(32); rb = pick(32); sf = 1'($urandom_range(0, 1));
            in_valid = 1'b1; op = 3'(opc); a = ra[31:0]; b = rb[31:0]; set_flags = sf;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready); end
            model(32, opc, ra, rb, mflags[1], er, ef);
            if (sf) mflags = ef;
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== er[31:0] || flags !== mflags)
                begin failures++;
                    $display("[TB] FAIL b2b op=%0d a=%h b=%h got=%b/%h/%b exp=1/%h/%b",
                             opc, ra[31:0], rb[31:0], out_valid, result, flags, er[31:0], mflags); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 32'd1000; b = 32'd3000; set_flags = 1'b1;
        tick();
        op = 3'd0; a = 32'd5; b = 32'd5;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0)
                begin failures++; $display("[TB] FAIL mul_busy k=%0d got=%b/%b exp=0/0", k, in_ready, out_valid); end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd3_000_000 || flags !== 4'b0000)
            begin failures++; $display("[TB] FAIL mul_result got=%b/%0d/%b exp=1/3000000/0000", out_valid, result, flags); end
        mflags = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd3_000_000 || in_ready !== 1'b0)
                begin failures++; $display("[TB] FAIL mul_hold k=%0d got=%b/%0d/%b exp=1/3000000/0", k, out_valid, result, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mul_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd10 || flags !== 4'b0000)
            begin failures++; $display("[TB] FAIL after_mul_add got=%b/%0d/%b exp=1/10/0000", out_valid, result, flags); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_slt_no_flags();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd1; a = 32'd1; b = 32'd2; set_flags = 1'b1;
        tick();
        checks++;
        if (result !== 32'hFFFF_FFFF || flags !== 4'b1000)
            begin failures++; $display("[TB] FAIL slt_setup got=%h/%b exp=ffffffff/1000", result, flags); end
        op = 3'd5; a = 32'hFFFF_FFFF; b = 32'd1; set_flags = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd1 || flags !== 4'b1000)
            begin failures++; $display("[TB] FAIL slt_signed got=%h/%b exp=1/1000", result, flags); end
        mflags = 4'b1000;
        tick();
    endtask

    task automatic test_random_mul();
        longint unsigned ra, rb, er;
        logic [3:0] ef;
        int lat;
        bit sf;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = pick(32); rb = longint'($urandom); sf = 1'($urandom_range(0, 1));
            in_valid = 1'b1; op = 3'd7; a = ra[31:0]; b = rb[31:0]; set_flags = sf;
            model(32, 7, ra, rb, 1'b0, er, ef);
            if (sf) mflags = ef;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
            checks++;
            if (lat != 32) begin failures++; $display("[TB] FAIL mul_latency got=%0d exp=32", lat); end
            checks++;
            if (result !== er[31:0] || flags !== mflags)
                begin failures++; $display("[TB] FAIL mul_rand a=%h b=%h got=%h/%b exp=%h/%b",
                                           ra[31:0], rb[31:0], result, flags, er[31:0], mflags); end
            tick();
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd0; a = 32'h7FFF_FFFF; b = 32'h1; set_flags = 1'b1;
        tick();
        op = 3'd7; a = 32'd12345; b = 32'd678;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || flags !== 4'b0000 || result !== 32'h0 || in_ready !== 1'b0)
            begin failures++; $display("[TB] FAIL mid_mul_reset got=%b/%b/%h/%b exp=0/0000/0/0",
                                       out_valid, flags, result, in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_mul_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; set_flags = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd5 || flags !== 4'b0000)
            begin failures++; $display("[TB] FAIL mid_mul_next got=%h/%b exp=5/0000", result, flags); end
        mflags = 4'b0000;
        stray = 0;
        repeat (40) begin tick(); if (out_valid !== 1'b0) stray++; end
        checks++;
        if (stray != 0) begin failures++; $display("[TB] FAIL mid_mul_stray got=%0d exp=0", stray); end
    endtask

    task automatic test_width8();
        longint unsigned ra, rb, er;
        logic [3:0] ef;
        int opc, lat, stray;
        bit sf;
        reset8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1;
        tick();
        checks++;
        if (out_valid8 !== 1'b0 || flags8 !== 4'b0000)
            begin failures++; $display("[TB] FAIL w8_reset got=%b/%b exp=0/0000", out_valid8, flags8); end
        reset8 = 1'b0;
        mflags8 = 4'b0000;
        in_valid8 = 1'b1; op8 = 3'd7; a8 = 8'd15; b8 = 8'd17; set_flags8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != 8 || result8 !== 8'hFF || flags8 !== 4'b1000)
            begin failures++; $display("[TB] FAIL w8_mul got=%0d/%h/%b exp=8/ff/1000", lat, result8, flags8); end
        mflags8 = 4'b1000;
        tick();
        for (int i = 0; i < 16; i++) begin
            opc = $urandom_range(0, 6);
            ra = pick(8); rb = pick(8); sf = 1'($urandom_range(0, 1));
            in_valid8 = 1'b1; op8 = 3'(opc); a8 = ra[7:0]; b8 = rb[7:0]; set_flags8 = sf;
            model(8, opc, ra, rb, mflags8[1], er, ef);
            if (sf) mflags8 = ef;
            tick();
            checks++;
            if (out_valid8 !== 1'b1 || result8 !== er[7:0] || flags8 !== mflags8)
                begin failures++; $display("[TB] FAIL w8_op op=%0d a=%h b=%h got=%h/%b exp=%h/%b",
                                           opc, ra[7:0], rb[7:0], result8, flags8, er[7:0], mflags8); end
        end
        op8 = 3'd7; a8 = 8'd9; b8 = 8'd7; set_flags8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (4) tick();
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || flags8 !== 4'b0000)
            begin failures++; $display("[TB] FAIL w8_mid_reset got=%b/%b exp=0/0000", out_valid8, flags8); end
        stray = 0;
        repeat (12) begin tick(); if (out_valid8 !== 1'b0) stray++; end
        checks++;
        if (stray != 0) begin failures++; $display("[TB] FAIL w8_stray got=%0d exp=0", stray); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; set_flags = 1'b0;
        reset8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0; set_flags8 = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_adc_chain();
        test_back_to_back();
        test_mul_backpressure();
        test_slt_no_flags();
        test_random_mul();
        test_reset_mid_mul();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
